// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment scan driver: active-low segment
// codes (bit order {g,f,e,d,c,b,a}), blink phase type and a width helper.
package seg7_pkg;

    localparam int SEG_W = 7;

    localparam logic [SEG_W-1:0] SEG_0     = 7'h40;
    localparam logic [SEG_W-1:0] SEG_1     = 7'h79;
    localparam logic [SEG_W-1:0] SEG_2     = 7'h24;
    localparam logic [SEG_W-1:0] SEG_3     = 7'h30;
    localparam logic [SEG_W-1:0] SEG_4     = 7'h19;
    localparam logic [SEG_W-1:0] SEG_5     = 7'h12;
    localparam logic [SEG_W-1:0] SEG_6     = 7'h02;
    localparam logic [SEG_W-1:0] SEG_7     = 7'h78;
    localparam logic [SEG_W-1:0] SEG_8     = 7'h00;
    localparam logic [SEG_W-1:0] SEG_9     = 7'h10;
    localparam logic [SEG_W-1:0] SEG_A     = 7'h08;
    localparam logic [SEG_W-1:0] SEG_B     = 7'h03;
    localparam logic [SEG_W-1:0] SEG_C     = 7'h46;
    localparam logic [SEG_W-1:0] SEG_D     = 7'h21;
    localparam logic [SEG_W-1:0] SEG_E     = 7'h06;
    localparam logic [SEG_W-1:0] SEG_F     = 7'h0E;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

    // Half of the blink cycle currently in effect.
    typedef enum logic {
        BLINK_OFF = 1'b0,
        BLINK_ON  = 1'b1
    } blink_ph_e;

    // Counter width for 0..n-1, never narrower than one bit.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Display data / pin bundle between the time-keeping logic (master) and the
// scan driver (slave). Pin outputs are active-low.
interface seg7_scan_driver_if #(
    parameter int N_DIG = 8,
    parameter int BW    = 3
);
    logic [7*N_DIG-1:0] SEG;
    logic [N_DIG-1:0]   DOT;
    logic [N_DIG-1:0]   BLANK;
    logic [N_DIG-1:0]   BLINK;
    logic [BW-1:0]      BRIGHT;
    logic               UPD;
    logic [N_DIG-1:0]   AN;
    logic [6:0]         C;
    logic               DP;
    logic               FRAME;

    modport master (
        output SEG, DOT, BLANK, BLINK, BRIGHT, UPD,
        input  AN, C, DP, FRAME
    );

    modport slave (
        input  SEG, DOT, BLANK, BLINK, BRIGHT, UPD,
        output AN, C, DP, FRAME
    );
endinterface

// File: rtl/seg7_scan_timer.sv
// Scan timebase: per-slot phase counter, digit index, frame-end strobe and
// blink phase that toggles every BLINK_FRAMES frames.
module seg7_scan_timer
    import seg7_pkg::*;
#(
    parameter int N_DIG        = 8,
    parameter int SCAN_W       = 17,
    parameter int BLINK_FRAMES = 64,
    parameter int IDX_W        = clog2_min1(N_DIG)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    output logic [SCAN_W-1:0] phase_o,
    output logic [IDX_W-1:0]  idx_o,
    output logic              frame_end_o,
    output blink_ph_e         blink_o
);

    localparam int              FC_W     = clog2_min1(BLINK_FRAMES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_DIG - 1);
    localparam logic [FC_W-1:0]  LAST_FC  = FC_W'(BLINK_FRAMES - 1);

    logic [SCAN_W-1:0] phase_q;
    logic [IDX_W-1:0]  idx_q;
    logic [FC_W-1:0]   fcnt_q;
    blink_ph_e         blink_q;
    logic              frame_end;

    // Last cycle of the last digit slot: the only point where frames hand over.
    assign frame_end = (&phase_q) && (idx_q == LAST_IDX);

    // Advance phase every cycle, digit on phase wrap, blink counter on frame end.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            phase_q <= '0;
            idx_q   <= '0;
            fcnt_q  <= '0;
            blink_q <= BLINK_ON;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values of the others.
            phase_q <= phase_q + SCAN_W'(1);
            if (&phase_q) begin
                idx_q <= (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
            end
            if (frame_end) begin
                if (fcnt_q == LAST_FC) begin
                    fcnt_q  <= '0;
                    blink_q <= (blink_q == BLINK_ON) ? BLINK_OFF : BLINK_ON;
                end else begin
                    fcnt_q <= fcnt_q + FC_W'(1);
                end
            end
        end
    end

    assign phase_o     = phase_q;
    assign idx_o       = idx_q;
    assign frame_end_o = frame_end;
    assign blink_o     = blink_q;

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed N-digit 7-segment scan driver. Display data is double-buffered
// (shadow -> live at frame end) so a frame is never torn; each slot opens with
// a guard band of dark cycles and brightness is a PWM on the slot's top phase bits.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int N_DIG        = 8,
    parameter int SCAN_W       = 17,
    parameter int BW           = 3,
    parameter int GUARD        = 4,
    parameter int BLINK_FRAMES = 64
) (
    input  logic              CP_100MHz,
    input  logic              CLR,
    seg7_scan_driver_if.slave bus
);

    localparam int                IDX_W    = clog2_min1(N_DIG);
    localparam logic [SCAN_W-1:0] GUARD_PH = SCAN_W'(GUARD);

    logic [SCAN_W-1:0] phase;
    logic [IDX_W-1:0]  idx;
    logic              frame_end;
    blink_ph_e         blink_ph;

    logic [N_DIG-1:0][SEG_W-1:0] shadow_seg_q, live_seg_q;
    logic [N_DIG-1:0]            shadow_dot_q, live_dot_q;
    logic [N_DIG-1:0]            shadow_blank_q, live_blank_q;
    logic [N_DIG-1:0]            shadow_blink_q, live_blink_q;
    logic                        pending_q;

    logic                        lit;
    logic                        bright_ok;
    logic [N_DIG-1:0]            an_d, an_q;
    logic [SEG_W-1:0]            c_d, c_q;
    logic                        dp_d, dp_q;
    logic                        frame_q;

    seg7_scan_timer #(
        .N_DIG        (N_DIG),
        .SCAN_W       (SCAN_W),
        .BLINK_FRAMES (BLINK_FRAMES),
        .IDX_W        (IDX_W)
    ) u_timer (
        .clk_i       (CP_100MHz),
        .rst_i       (CLR),
        .phase_o     (phase),
        .idx_o       (idx),
        .frame_end_o (frame_end),
        .blink_o     (blink_ph)
    );

    // Update handshake: UPD loads the shadow; a pending shadow moves to live at
    // frame end unless a new UPD lands on that same cycle.
    always_ff @(posedge CP_100MHz) begin
        if (CLR) begin
            // NOTE: shadow/live are reset on purpose so the display is dark until the first commit.
            shadow_seg_q   <= {N_DIG{SEG_BLANK}};
            shadow_dot_q   <= '0;
            shadow_blank_q <= '1;
            shadow_blink_q <= '0;
            live_seg_q     <= {N_DIG{SEG_BLANK}};
            live_dot_q     <= '0;
            live_blank_q   <= '1;
            live_blink_q   <= '0;
            pending_q      <= 1'b0;
        end else if (bus.UPD) begin
            shadow_seg_q   <= bus.SEG;
            shadow_dot_q   <= bus.DOT;
            shadow_blank_q <= bus.BLANK;
            shadow_blink_q <= bus.BLINK;
            pending_q      <= 1'b1;
        end else if (frame_end && pending_q) begin
            live_seg_q   <= shadow_seg_q;
            live_dot_q   <= shadow_dot_q;
            live_blank_q <= shadow_blank_q;
            live_blink_q <= shadow_blink_q;
            pending_q    <= 1'b0;
        end
    end

    // Lit decision for the current slot and the pin values that follow from it.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        an_d      = '1;
        c_d       = SEG_BLANK;
        dp_d      = 1'b1;
        bright_ok = (bus.BRIGHT == '1) || (phase[SCAN_W-1 -: BW] < bus.BRIGHT);
        lit       = (phase >= GUARD_PH) && bright_ok && !live_blank_q[idx]
                    && !(live_blink_q[idx] && (blink_ph == BLINK_OFF));
        if (lit) begin
            an_d[idx] = 1'b0;
            c_d       = live_seg_q[idx];
            dp_d      = ~live_dot_q[idx];
        end
    end

    // Register all pins so they are glitch-free at the board.
    always_ff @(posedge CP_100MHz) begin
        if (CLR) begin
            an_q    <= '1;
            c_q     <= SEG_BLANK;
            dp_q    <= 1'b1;
            frame_q <= 1'b0;
        end else begin
            an_q    <= an_d;
            c_q     <= c_d;
            dp_q    <= dp_d;
            frame_q <= frame_end;
        end
    end

    assign bus.AN    = an_q;
    assign bus.C     = c_q;
    assign bus.DP    = dp_q;
    assign bus.FRAME = frame_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with N_DIG=8, SCAN_W=4, BW=2, GUARD=2,
// BLINK_FRAMES=2: slot = 16 cycles, frame = 128 cycles.
// n counts non-reset clock edges since the last reset release; outputs seen
// after edge n reflect counter state s = n-1 (phase = s%16, digit = (s/16)%8).
module tb_seg7_scan_driver;
    import seg7_pkg::*;

    logic clk;
    logic clr;
    int   n;
    int   n_checks;
    int   n_fail;

    seg7_scan_driver_if #(.N_DIG(8), .BW(2)) bus ();

    seg7_scan_driver #(
        .N_DIG        (8),
        .SCAN_W       (4),
        .BW           (2),
        .GUARD        (2),
        .BLINK_FRAMES (2)
    ) dut (
        .CP_100MHz (clk),
        .CLR       (clr),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        n = n + 1;
    endtask

    task automatic run_to(input int target);
        while (n < target) step();
    endtask

    task automatic test_reset();
        clr        = 1'b1;
        bus.SEG    = {8{SEG_BLANK}};
        bus.DOT    = 8'h00;
        bus.BLANK  = 8'hFF;
        bus.BLINK  = 8'h00;
        bus.BRIGHT = 2'd3;
        bus.UPD    = 1'b0;
        step();
        step();
        n_checks++; if (bus.AN !== 8'hFF) begin n_fail++; $display("FAIL reset_an: got %h expected ff", bus.AN); end
        n_checks++; if (bus.C !== 7'h7F) begin n_fail++; $display("FAIL reset_c: got %h expected 7f", bus.C); end
        n_checks++; if (bus.DP !== 1'b1) begin n_fail++; $display("FAIL reset_dp: got %b expected 1", bus.DP); end
        n_checks++; if (bus.FRAME !== 1'b0) begin n_fail++; $display("FAIL reset_frame: got %b expected 0", bus.FRAME); end
        clr = 1'b0;
        n   = 0;
    endtask

    // Digits 0/1 shown from the second frame on; frame 0 stays dark.
    task automatic test_basic();
        int         s, ph, ix, fr;
        bit         lit;
        logic [7:0] exp_an;
        logic [6:0] exp_c;
        logic       exp_fr;
        bus.SEG[6:0]  = SEG_0;
        bus.SEG[13:7] = SEG_1;
        bus.BLANK     = 8'hFC;
        bus.UPD       = 1'b1;
        for (int k = 0; k < 256; k++) begin
            step();
            bus.UPD = 1'b0;
            s  = n - 1;
            ph = s % 16;
            ix = (s / 16) % 8;
            fr = s / 128;
            lit    = (fr >= 1) && (ph >= 2) && (ix < 2);
            exp_an = lit ? ~(8'h01 << ix) : 8'hFF;
            exp_c  = !lit ? 7'h7F : ((ix == 0) ? 7'h40 : 7'h79);
            exp_fr = (n % 128) == 0;
            n_checks++; if (bus.AN !== exp_an) begin n_fail++; $display("FAIL basic_an n=%0d: got %h expected %h", n, bus.AN, exp_an); end
            n_checks++; if (bus.C !== exp_c) begin n_fail++; $display("FAIL basic_c n=%0d: got %h expected %h", n, bus.C, exp_c); end
            n_checks++; if (bus.DP !== 1'b1) begin n_fail++; $display("FAIL basic_dp n=%0d: got %b expected 1", n, bus.DP); end
            n_checks++; if (bus.FRAME !== exp_fr) begin n_fail++; $display("FAIL basic_frame n=%0d: got %b expected %b", n, bus.FRAME, exp_fr); end
        end
    endtask

    // UPD mid-frame, then SEG changes without UPD: only the captured value appears, at frame end.
    task automatic test_hold();
        run_to(260);
        bus.SEG[6:0] = SEG_2;
        bus.UPD      = 1'b1;
        step();
        bus.UPD      = 1'b0;
        bus.SEG[6:0] = SEG_3;
        run_to(265);
        n_checks++; if (bus.C !== 7'h40) begin n_fail++; $display("FAIL hold_old: got %h expected 40", bus.C); end
        run_to(388);
        n_checks++; if (bus.AN !== 8'hFE) begin n_fail++; $display("FAIL hold_an: got %h expected fe", bus.AN); end
        n_checks++; if (bus.C !== 7'h24) begin n_fail++; $display("FAIL hold_new: got %h expected 24", bus.C); end
        run_to(396);
        n_checks++; if (bus.C !== 7'h24) begin n_fail++; $display("FAIL hold_shadow_only: got %h expected 24", bus.C); end
        run_to(404);
        n_checks++; if (bus.AN !== 8'hFD) begin n_fail++; $display("FAIL hold_d1_an: got %h expected fd", bus.AN); end
        n_checks++; if (bus.C !== 7'h79) begin n_fail++; $display("FAIL hold_d1_c: got %h expected 79", bus.C); end
    endtask

    // UPD on the frame-end cycle commits one frame later.
    task automatic test_upd_frame_end();
        run_to(511);
        n_checks++; if (bus.FRAME !== 1'b0) begin n_fail++; $display("FAIL fe_pre_frame: got %b expected 0", bus.FRAME); end
        bus.SEG[6:0] = SEG_5;
        bus.UPD      = 1'b1;
        step();
        bus.UPD = 1'b0;
        n_checks++; if (bus.FRAME !== 1'b1) begin n_fail++; $display("FAIL fe_frame: got %b expected 1", bus.FRAME); end
        run_to(520);
        n_checks++; if (bus.C !== 7'h24) begin n_fail++; $display("FAIL fe_not_yet: got %h expected 24", bus.C); end
        run_to(648);
        n_checks++; if (bus.AN !== 8'hFE) begin n_fail++; $display("FAIL fe_commit_an: got %h expected fe", bus.AN); end
        n_checks++; if (bus.C !== 7'h12) begin n_fail++; $display("FAIL fe_commit_c: got %h expected 12", bus.C); end
    endtask

    // BRIGHT=1: lit only at phase 2..3; BRIGHT=0: dark.
    task automatic test_bright();
        int         ph;
        logic [7:0] exp_an;
        logic [6:0] exp_c;
        run_to(700);
        bus.BRIGHT = 2'd1;
        run_to(768);
        for (int k = 0; k < 16; k++) begin
            step();
            ph     = (n - 1) % 16;
            exp_an = (ph == 2 || ph == 3) ? 8'hFE : 8'hFF;
            exp_c  = (ph == 2 || ph == 3) ? 7'h12 : 7'h7F;
            n_checks++; if (bus.AN !== exp_an) begin n_fail++; $display("FAIL bright1_an n=%0d: got %h expected %h", n, bus.AN, exp_an); end
            n_checks++; if (bus.C !== exp_c) begin n_fail++; $display("FAIL bright1_c n=%0d: got %h expected %h", n, bus.C, exp_c); end
        end
        run_to(800);
        bus.BRIGHT = 2'd0;
        run_to(896);
        for (int k = 0; k < 32; k++) begin
            step();
            n_checks++; if (bus.AN !== 8'hFF) begin n_fail++; $display("FAIL bright0_an n=%0d: got %h expected ff", n, bus.AN); end
        end
    endtask

    // Blink on digit 0 with its DP, then reset mid-frame and check realignment.
    task automatic test_blink_and_clr();
        bit         on;
        logic [7:0] exp_an;
        logic [6:0] exp_c;
        logic       exp_dp;
        run_to(928);
        bus.BRIGHT = 2'd3;
        bus.DOT    = 8'h01;
        bus.BLINK  = 8'h01;
        bus.UPD    = 1'b1;
        step();
        bus.UPD = 1'b0;
        for (int fr = 8; fr <= 12; fr++) begin
            run_to(fr * 128 + 9);
            on     = (fr == 8) || (fr == 9) || (fr == 12);
            exp_an = on ? 8'hFE : 8'hFF;
            exp_c  = on ? 7'h12 : 7'h7F;
            exp_dp = on ? 1'b0 : 1'b1;
            n_checks++; if (bus.AN !== exp_an) begin n_fail++; $display("FAIL blink_an fr=%0d: got %h expected %h", fr, bus.AN, exp_an); end
            n_checks++; if (bus.C !== exp_c) begin n_fail++; $display("FAIL blink_c fr=%0d: got %h expected %h", fr, bus.C, exp_c); end
            n_checks++; if (bus.DP !== exp_dp) begin n_fail++; $display("FAIL blink_dp fr=%0d: got %b expected %b", fr, bus.DP, exp_dp); end
            if (fr == 10) begin
                run_to(1305);
                n_checks++; if (bus.AN !== 8'hFD) begin n_fail++; $display("FAIL blink_d1_an: got %h expected fd", bus.AN); end
                n_checks++; if (bus.DP !== 1'b1) begin n_fail++; $display("FAIL blink_d1_dp: got %b expected 1", bus.DP); end
            end
        end
        clr = 1'b1;
        step();
        n_checks++; if (bus.AN !== 8'hFF) begin n_fail++; $display("FAIL clr_an: got %h expected ff", bus.AN); end
        n_checks++; if (bus.C !== 7'h7F) begin n_fail++; $display("FAIL clr_c: got %h expected 7f", bus.C); end
        n_checks++; if (bus.DP !== 1'b1) begin n_fail++; $display("FAIL clr_dp: got %b expected 1", bus.DP); end
        clr     = 1'b0;
        n       = 0;
        bus.UPD = 1'b1;
        step();
        bus.UPD = 1'b0;
        run_to(9);
        n_checks++; if (bus.AN !== 8'hFF) begin n_fail++; $display("FAIL clr_dark: got %h expected ff", bus.AN); end
        run_to(127);
        n_checks++; if (bus.FRAME !== 1'b0) begin n_fail++; $display("FAIL clr_frame_early: got %b expected 0", bus.FRAME); end
        step();
        n_checks++; if (bus.FRAME !== 1'b1) begin n_fail++; $display("FAIL clr_frame: got %b expected 1", bus.FRAME); end
        run_to(137);
        n_checks++; if (bus.AN !== 8'hFE) begin n_fail++; $display("FAIL clr_d0_an: got %h expected fe", bus.AN); end
        n_checks++; if (bus.DP !== 1'b0) begin n_fail++; $display("FAIL clr_d0_dp: got %b expected 0", bus.DP); end
        run_to(150);
        n_checks++; if (bus.AN !== 8'hFD) begin n_fail++; $display("FAIL clr_d1_an: got %h expected fd", bus.AN); end
        n_checks++; if (bus.C !== 7'h79) begin n_fail++; $display("FAIL clr_d1_c: got %h expected 79", bus.C); end
        run_to(265);
        n_checks++; if (bus.AN !== 8'hFF) begin n_fail++; $display("FAIL clr_blink_off: got %h expected ff", bus.AN); end
    endtask

    initial begin
        n        = 0;
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_basic();
        test_hold();
        test_upd_frame_end();
        test_bright();
        test_blink_and_clr();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
